// File: rtl/clock_divider_mc.sv
// Multi-channel decimating clock divider. Each channel holds a shadowed {ratio, delay, mode}
// that is applied only from OFF/DELAY, at a period boundary, or on a global sync.
module clock_divider_mc #(
  parameter int NUM_CH  = 4,
  parameter int RATIO_W = 8,
  parameter int DELAY_W = 8,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [RATIO_W-1:0] cfg_ratio,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic [1:0]         cfg_mode,
  input  logic               sync,
  output logic [NUM_CH-1:0]  dec_clk,
  output logic [NUM_CH-1:0]  phase_tick
);

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_SQUARE = 2'd1;
  localparam logic [1:0] MODE_PULSE  = 2'd2;
  localparam int         CH_SPAN     = 1 << CH_W;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2
  } ch_state_e;

  logic [NUM_CH-1:0]  pending_s;
  logic [CH_SPAN-1:0] pending_span_s;
  logic               cfg_in_range_s;
  logic               cfg_accept_s;

  // Ratios of 0 and 1 both behave as 2.
  function automatic logic [RATIO_W-1:0] eff_ratio(input logic [RATIO_W-1:0] ratio);
    logic [RATIO_W-1:0] r;
    if (ratio < RATIO_W'(2)) begin
      r = RATIO_W'(2);
    end else begin
      r = ratio;
    end
    return r;
  endfunction

  function automatic logic mode_on(input logic [1:0] mode);
    return (mode == MODE_SQUARE) || (mode == MODE_PULSE);
  endfunction

  // {dec_clk, phase_tick} for a given position in the period; SQUARE is high for ceil(Neff/2).
  function automatic logic [1:0] period_out(input logic [1:0]         mode,
                                            input logic [RATIO_W-1:0] cnt,
                                            input logic [RATIO_W-1:0] neff);
    logic [RATIO_W:0] half;
    logic             dec;
    logic             tick;
    half = ({1'b0, neff} + {{RATIO_W{1'b0}}, 1'b1}) >> 1;
    tick = (cnt == {RATIO_W{1'b0}});
    case (mode)
      MODE_SQUARE: dec = ({1'b0, cnt} < half);
      MODE_PULSE:  dec = tick;
      default: begin
        dec  = 1'b0;
        tick = 1'b0;
      end
    endcase
    return {dec, tick};
  endfunction

  assign pending_span_s = CH_SPAN'(pending_s);
  assign cfg_in_range_s = (32'(cfg_ch) < 32'(NUM_CH));
  assign cfg_accept_s   = cfg_valid && cfg_ready && cfg_in_range_s;

  // Out-of-range channels are always ready so their writes drain harmlessly.
  always_comb begin
    if (cfg_in_range_s) begin
      cfg_ready = !pending_span_s[cfg_ch];
    end else begin
      cfg_ready = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_state_e          state_r, state_nxt_s;
    logic [RATIO_W-1:0] cnt_r, cnt_nxt_s;
    logic [DELAY_W-1:0] dly_r, dly_nxt_s;
    logic [RATIO_W-1:0] act_ratio_r, sh_ratio_r, ratio_sel_s, neff_act_s, neff_sel_s;
    logic [DELAY_W-1:0] act_delay_r, sh_delay_r, delay_sel_s;
    logic [1:0]         act_mode_r, sh_mode_r, mode_sel_s;
    logic               pending_r;
    logic               dec_r, tick_r;
    logic               wr_s, boundary_s, apply_s, sel_on_s;
    logic [1:0]         out_s;

    assign wr_s          = cfg_accept_s && (cfg_ch == CH_W'(g));
    assign pending_s[g]  = pending_r;
    assign dec_clk[g]    = dec_r;
    assign phase_tick[g] = tick_r;

    // Next state, counters and the values the output flops take at this edge.
    always_comb begin
      neff_act_s = eff_ratio(act_ratio_r);
      boundary_s = (state_r == ST_RUN) && (cnt_r == neff_act_s - RATIO_W'(1));
      apply_s    = pending_r && ((state_r != ST_RUN) || sync || boundary_s);
      if (apply_s) begin
        ratio_sel_s = sh_ratio_r;
        delay_sel_s = sh_delay_r;
        mode_sel_s  = sh_mode_r;
      end else begin
        ratio_sel_s = act_ratio_r;
        delay_sel_s = act_delay_r;
        mode_sel_s  = act_mode_r;
      end
      neff_sel_s  = eff_ratio(ratio_sel_s);
      sel_on_s    = mode_on(mode_sel_s);
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      dly_nxt_s   = dly_r;
      out_s       = 2'b00;

      if (sync && (state_r != ST_OFF)) begin
        if (sel_on_s) begin
          state_nxt_s = ST_DELAY;
          dly_nxt_s   = delay_sel_s;
        end else begin
          state_nxt_s = ST_OFF;
        end
      end else begin
        case (state_r)
          ST_OFF: begin
            if (apply_s && sel_on_s) begin
              state_nxt_s = ST_DELAY;
              dly_nxt_s   = delay_sel_s;
            end else begin
              state_nxt_s = ST_OFF;
            end
          end
          ST_DELAY: begin
            if (apply_s) begin
              if (sel_on_s) begin
                state_nxt_s = ST_DELAY;
                dly_nxt_s   = delay_sel_s;
              end else begin
                state_nxt_s = ST_OFF;
              end
            end else if (dly_r == {DELAY_W{1'b0}}) begin
              state_nxt_s = ST_RUN;
              cnt_nxt_s   = {RATIO_W{1'b0}};
              out_s       = period_out(mode_sel_s, {RATIO_W{1'b0}}, neff_sel_s);
            end else begin
              dly_nxt_s = dly_r - DELAY_W'(1);
            end
          end
          ST_RUN: begin
            if (boundary_s) begin
              if (sel_on_s) begin
                cnt_nxt_s = {RATIO_W{1'b0}};
                out_s     = period_out(mode_sel_s, {RATIO_W{1'b0}}, neff_sel_s);
              end else begin
                state_nxt_s = ST_OFF;
              end
            end else begin
              cnt_nxt_s = cnt_r + RATIO_W'(1);
              out_s     = period_out(mode_sel_s, cnt_r + RATIO_W'(1), neff_sel_s);
            end
          end
          default: begin
            state_nxt_s = ST_OFF;
          end
        endcase
      end
    end

    // Channel state, shadow/active configuration and registered outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r     <= ST_OFF;
        cnt_r       <= {RATIO_W{1'b0}};
        dly_r       <= {DELAY_W{1'b0}};
        act_ratio_r <= {RATIO_W{1'b0}};
        act_delay_r <= {DELAY_W{1'b0}};
        act_mode_r  <= MODE_OFF;
        sh_ratio_r  <= {RATIO_W{1'b0}};
        sh_delay_r  <= {DELAY_W{1'b0}};
        sh_mode_r   <= MODE_OFF;
        pending_r   <= 1'b0;
        dec_r       <= 1'b0;
        tick_r      <= 1'b0;
      end else begin
        state_r <= state_nxt_s;
        cnt_r   <= cnt_nxt_s;
        dly_r   <= dly_nxt_s;
        dec_r   <= out_s[1];
        tick_r  <= out_s[0];
        if (apply_s) begin
          act_ratio_r <= sh_ratio_r;
          act_delay_r <= sh_delay_r;
          act_mode_r  <= sh_mode_r;
          pending_r   <= 1'b0;
        end else if (wr_s) begin
          sh_ratio_r <= cfg_ratio;
          sh_delay_r <= cfg_delay;
          sh_mode_r  <= cfg_mode;
          pending_r  <= 1'b1;
        end else begin
          pending_r <= pending_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_divider_mc.sv
// Directed bench for clock_divider_mc: fixed stimulus with hand-derived output sequences.
module tb_clock_divider_mc;
  localparam int NCH = 6;
  localparam int CHW = 3;

  logic           clk;
  logic           rst;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [7:0]     cfg_ratio;
  logic [7:0]     cfg_delay;
  logic [1:0]     cfg_mode;
  logic           sync;
  logic [NCH-1:0] dec_clk;
  logic [NCH-1:0] phase_tick;

  int errors;
  int checks;

  clock_divider_mc #(.NUM_CH(NCH), .RATIO_W(8), .DELAY_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_ratio  (cfg_ratio),
    .cfg_delay  (cfg_delay),
    .cfg_mode   (cfg_mode),
    .sync       (sync),
    .dec_clk    (dec_clk),
    .phase_tick (phase_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    cfg_valid = 1'b0;
    sync      = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns 1ns after the accepting edge.
  task automatic cfg_write(input logic [CHW-1:0] ch, input logic [7:0] ratio,
                           input logic [7:0] delay, input logic [1:0] mode);
    int waited;
    waited = 0;
    @(negedge clk);
    cfg_ch    = ch;
    cfg_ratio = ratio;
    cfg_delay = delay;
    cfg_mode  = mode;
    cfg_valid = 1'b1;
    while (!cfg_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!cfg_ready) begin
      check("wr_timeout", 32'(cfg_ready), 32'd1);
      cfg_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 cfg_valid = 1'b0;
    end
  endtask

  // Expected patterns are MSB-first: leftmost bit is the first sampled cycle.
  task automatic watch(input string tag, input logic [NCH-1:0] mask, input int n,
                       input logic [31:0] dec_exp, input logic [31:0] tick_exp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        if (mask[c]) begin
          check($sformatf("%s_dec_ch%0d_cyc%0d", tag, c, i), 32'(dec_clk[c]), 32'(dec_exp[n-1-i]));
          check($sformatf("%s_tick_ch%0d_cyc%0d", tag, c, i), 32'(phase_tick[c]), 32'(tick_exp[n-1-i]));
        end
      end
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = 3'd0;
    cfg_ratio = 8'd0;
    cfg_delay = 8'd0;
    cfg_mode  = 2'd0;
    sync      = 1'b0;

    do_reset();
    check("rst_dec", 32'(dec_clk), 32'd0);
    check("rst_tick", 32'(phase_tick), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);

    // SQUARE N=4 D=0, then a mid-period change to N=6.
    cfg_write(3'd0, 8'd4, 8'd0, 2'd1);
    watch("sq4", 6'b000001, 10, 32'b0011001100, 32'b0010001000);
    @(negedge clk);
    cfg_write(3'd0, 8'd6, 8'd0, 2'd1);
    check("ready_pending", 32'(cfg_ready), 32'd0);
    watch("sq6", 6'b000001, 9, 32'b001110001, 32'b001000001);
    check("ready_applied", 32'(cfg_ready), 32'd1);

    // PULSE N=5 D=3, then N=0 and N=1 on another channel.
    do_reset();
    cfg_write(3'd1, 8'd5, 8'd3, 2'd2);
    watch("pulse5", 6'b000010, 11, 32'b00000100001, 32'b00000100001);
    cfg_write(3'd2, 8'd0, 8'd0, 2'd2);
    watch("n0", 6'b000100, 7, 32'b0010101, 32'b0010101);
    cfg_write(3'd2, 8'd1, 8'd0, 2'd1);
    watch("n1", 6'b000100, 6, 32'b101010, 32'b101010);

    // Two channels out of phase realigned by sync.
    do_reset();
    cfg_write(3'd0, 8'd4, 8'd2, 2'd1);
    cfg_write(3'd2, 8'd8, 8'd2, 2'd1);
    repeat (10) @(negedge clk);
    @(negedge clk);
    sync = 1'b1;
    @(posedge clk);
    #1 sync = 1'b0;
    watch("sync", 6'b000101, 5, 32'b00011, 32'b00010);

    // Out-of-range channel write, then OFF written to a running channel.
    do_reset();
    cfg_write(3'd7, 8'd2, 8'd0, 2'd1);
    check("oor_ready", 32'(cfg_ready), 32'd1);
    cfg_ch = 3'd3;
    #1 check("oor_alias_ready", 32'(cfg_ready), 32'd1);
    watch("oor", 6'b111111, 4, 32'd0, 32'd0);
    cfg_write(3'd0, 8'd4, 8'd0, 2'd1);
    repeat (2) @(negedge clk);
    cfg_write(3'd0, 8'd4, 8'd0, 2'd0);
    watch("off", 6'b000001, 8, 32'b10000000, 32'd0);

    // Reset mid-period with a write still pending.
    do_reset();
    cfg_write(3'd1, 8'd3, 8'd0, 2'd2);
    cfg_write(3'd2, 8'd6, 8'd1, 2'd1);
    cfg_write(3'd0, 8'd4, 8'd0, 2'd1);
    repeat (2) @(negedge clk);
    cfg_write(3'd0, 8'd2, 8'd0, 2'd2);
    @(negedge clk);
    check("pend_pre_rst", 32'(cfg_ready), 32'd0);
    check("run_pre_rst", 32'(dec_clk[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_dec", 32'(dec_clk), 32'd0);
    check("mid_rst_tick", 32'(phase_tick), 32'd0);
    check("mid_rst_ready", 32'(cfg_ready), 32'd1);
    rst = 1'b0;
    watch("post_rst", 6'b111111, 6, 32'd0, 32'd0);
    check("post_rst_ready", 32'(cfg_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
